multicycle_controller: RTL and testbench

//  Moore-style control FSM that sequences a shared-ALU, shared-memory RV32I-subset datapath
//  (lw, sw, R-type, I-type ALU, beq, jal) over several cycles. It sits beside the datapath,

---
 rtl/multicycle_controller.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control FSM: sequences a shared-ALU, shared-memory datapath.
// Optional MEM_WAIT_EN adds mem_ready and holds FETCH/MEMREAD/MEMWRITE until it is high.
module multicycle_controller #(
   parameter bit ILLEGAL_TO_FETCH = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
`ifdef MEM_WAIT_EN
   input  logic       mem_ready,
`endif
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_control,
   output logic [1:0] imm_src,
   output logic       reg_write,
   output logic [3:0] state,
   output logic       illegal
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_HALT     = 4'd11
   } state_t;

   state_t     state_q, state_d;
   logic       ready;
   logic       pc_update, branch;
   logic       mem_write_s, ir_write_s, reg_write_s;
   logic [1:0] alu_op;

`ifdef MEM_WAIT_EN
   assign ready = mem_ready;
`else
   assign ready = 1'b1;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Next state and Moore controls
   always_comb begin
      state_d     = state_q;
      adr_src     = 1'b0;
      mem_write_s = 1'b0;
      ir_write_s  = 1'b0;
      reg_write_s = 1'b0;
      pc_update   = 1'b0;
      branch      = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_op      = 2'b00;
      illegal     = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_write_s = ready;
            pc_update  = ready;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            if (ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default: begin
                  illegal = 1'b1;
                  state_d = ILLEGAL_TO_FETCH ? S_FETCH : S_HALT;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            if (ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src  = 2'b01;
            reg_write_s = 1'b1;
            state_d     = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src     = 1'b1;
            mem_write_s = 1'b1;
            if (ready) state_d = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
            state_d   = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_s = 1'b1;
            state_d     = S_FETCH;
         end
         S_BEQ: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            branch    = 1'b1;
            state_d   = S_FETCH;
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
            state_d   = S_ALUWB;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // ALU decoder
   always_comb begin
      alu_control = 3'b000;
      case (alu_op)
         2'b01: alu_control = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  alu_control = (op[5] && funct7b5) ? 3'b001 : 3'b000;
               3'b010:  alu_control = 3'b101;
               3'b110:  alu_control = 3'b011;
               3'b111:  alu_control = 3'b010;
               default: alu_control = 3'b000;
            endcase
         end
         default: alu_control = 3'b000;
      endcase
   end

   // Immediate format follows the opcode regardless of state
   always_comb begin
      case (op)
         OP_SW:   imm_src = 2'b01;
         OP_BEQ:  imm_src = 2'b10;
         OP_JAL:  imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

   // Enables are gated off while reset is held
   assign pc_write  = rst_n & (pc_update | (branch & zero));
   assign ir_write  = rst_n & ir_write_s;
   assign mem_write = rst_n & mem_write_s;
   assign reg_write = rst_n & reg_write_s;
   assign state     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed table, randomized model
// comparison, reset abort, illegal/HALT handling and (with MEM_WAIT_EN) memory stalls.
module tb_multicycle_controller;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, adr, mw, irw;
      logic [1:0] res, sa, sb;
      logic [2:0] alu;
      logic [1:0] imm;
      logic       rw, ill;
   } ctl_t;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic       z;
      int         len;
      logic [2:0] exec_alu;
      int         pcw_n;
      int         rw_n;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic funct7b5, zero;
`ifdef MEM_WAIT_EN
   logic mem_ready;
`endif
   logic a_pcw, a_adr, a_mw, a_irw, a_rw, a_ill;
   logic [1:0] a_res, a_sa, a_sb, a_imm;
   logic [2:0] a_alu;
   logic [3:0] a_st;
   logic b_pcw, b_adr, b_mw, b_irw, b_rw, b_ill;
   logic [1:0] b_res, b_sa, b_sb, b_imm;
   logic [2:0] b_alu;
   logic [3:0] b_st;
   ctl_t a_ctl, b_ctl;

   int checks = 0;
   int failures = 0;
   ctl_t exp_q[$];
   vec_t vecs[$];

   always #5 clk = ~clk;

   multicycle_controller #(.ILLEGAL_TO_FETCH(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
`ifdef MEM_WAIT_EN
      .mem_ready(mem_ready),
`endif
      .pc_write(a_pcw), .adr_src(a_adr), .mem_write(a_mw), .ir_write(a_irw),
      .result_src(a_res), .alu_src_a(a_sa), .alu_src_b(a_sb), .alu_control(a_alu),
      .imm_src(a_imm), .reg_write(a_rw), .state(a_st), .illegal(a_ill));

   multicycle_controller #(.ILLEGAL_TO_FETCH(1'b0)) u_b (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
`ifdef MEM_WAIT_EN
      .mem_ready(mem_ready),
`endif
      .pc_write(b_pcw), .adr_src(b_adr), .mem_write(b_mw), .ir_write(b_irw),
      .result_src(b_res), .alu_src_a(b_sa), .alu_src_b(b_sb), .alu_control(b_alu),
      .imm_src(b_imm), .reg_write(b_rw), .state(b_st), .illegal(b_ill));

   assign a_ctl = {a_st, a_pcw, a_adr, a_mw, a_irw, a_res, a_sa, a_sb, a_alu, a_imm, a_rw, a_ill};
   assign b_ctl = {b_st, b_pcw, b_adr, b_mw, b_irw, b_res, b_sa, b_sb, b_alu, b_imm, b_rw, b_ill};

   function automatic ctl_t mk(input logic [3:0] st, input logic pcw, input logic adr,
                               input logic mw, input logic irw, input logic [1:0] res,
                               input logic [1:0] sa, input logic [1:0] sb,
                               input logic [2:0] alu, input logic [1:0] imm,
                               input logic rw, input logic ill);
      return {st, pcw, adr, mw, irw, res, sa, sb, alu, imm, rw, ill};
   endfunction

   function automatic logic [1:0] exp_imm(input logic [6:0] o);
      if (o == 7'b0100011) return 2'b01;
      if (o == 7'b1100011) return 2'b10;
      if (o == 7'b1101111) return 2'b11;
      return 2'b00;
   endfunction

   function automatic logic [2:0] exp_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      case (f3)
         3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   function automatic bit is_legal(input logic [6:0] o);
      return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
             o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
   endfunction

   task automatic chk(input string name, input ctl_t act, input ctl_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected per-cycle control trace of one instruction, starting with its FETCH
   task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
      logic [1:0] im;
      ctl_t wb;
      im = exp_imm(o);
      wb = mk(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, im, 1, 0);
      exp_q.delete();
      exp_q.push_back(mk(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, im, 0, 0));
      exp_q.push_back(mk(4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, im, 0, !is_legal(o)));
      case (o)
         7'b0000011: begin
            exp_q.push_back(mk(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, im, 0, 0));
            exp_q.push_back(mk(4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, im, 0, 0));
            exp_q.push_back(mk(4'd4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, im, 1, 0));
         end
         7'b0100011: begin
            exp_q.push_back(mk(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, im, 0, 0));
            exp_q.push_back(mk(4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, im, 0, 0));
         end
         7'b0110011: begin
            exp_q.push_back(mk(4'd6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, exp_alu(o, f3, f7), im, 0, 0));
            exp_q.push_back(wb);
         end
         7'b0010011: begin
            exp_q.push_back(mk(4'd7, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, exp_alu(o, f3, f7), im, 0, 0));
            exp_q.push_back(wb);
         end
         7'b1100011:
            exp_q.push_back(mk(4'd9, z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, im, 0, 0));
         7'b1101111: begin
            exp_q.push_back(mk(4'd10, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, im, 0, 0));
            exp_q.push_back(wb);
         end
         default: ;
      endcase
   endtask

   task automatic run_model(input string name);
      foreach (exp_q[i]) begin
         @(negedge clk);
         chk($sformatf("%s_cyc%0d", name, i), a_ctl, exp_q[i]);
         step();
      end
   endtask

   // Runs one instruction from FETCH and summarises what the DUT did
   task automatic run_vec(input int idx, input vec_t v);
      int n, pcw_n, rw_n;
      logic [2:0] ealu;
      bit done;
      op = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.z;
      n = 0; pcw_n = 0; rw_n = 0; ealu = 3'b000; done = 0;
      chk_int($sformatf("vec%0d_start_state", idx), int'(a_st), 0);
      for (int c = 0; c < 16 && !done; c++) begin
         @(negedge clk);
         pcw_n += int'(a_pcw);
         rw_n  += int'(a_rw);
         if (a_st == 4'd6 || a_st == 4'd7 || a_st == 4'd9) ealu = a_alu;
         step();
         n++;
         if (a_st == 4'd0) done = 1;
      end
      chk_int($sformatf("vec%0d_len", idx), n, v.len);
      chk_int($sformatf("vec%0d_pcw_cycles", idx), pcw_n, v.pcw_n);
      chk_int($sformatf("vec%0d_rw_cycles", idx), rw_n, v.rw_n);
      chk_int($sformatf("vec%0d_exec_alu", idx), int'(ealu), int'(v.exec_alu));
   endtask

   initial begin
      logic [6:0] o;
      logic [6:0] legal_ops [6];
      bit ok;
      legal_ops[0] = 7'b0000011; legal_ops[1] = 7'b0100011; legal_ops[2] = 7'b0110011;
      legal_ops[3] = 7'b0010011; legal_ops[4] = 7'b1100011; legal_ops[5] = 7'b1101111;

      //        op           f3      f7    z     len alu     pcw rw
      vecs.push_back('{7'b0000011, 3'b000, 1'b0, 1'b0, 5, 3'b000, 1, 1});
      vecs.push_back('{7'b0100011, 3'b010, 1'b0, 1'b0, 4, 3'b000, 1, 0});
      vecs.push_back('{7'b0110011, 3'b000, 1'b0, 1'b0, 4, 3'b000, 1, 1});
      vecs.push_back('{7'b0110011, 3'b000, 1'b1, 1'b0, 4, 3'b001, 1, 1});
      vecs.push_back('{7'b0110011, 3'b010, 1'b0, 1'b0, 4, 3'b101, 1, 1});
      vecs.push_back('{7'b0110011, 3'b110, 1'b0, 1'b0, 4, 3'b011, 1, 1});
      vecs.push_back('{7'b0110011, 3'b111, 1'b1, 1'b0, 4, 3'b010, 1, 1});
      vecs.push_back('{7'b0110011, 3'b001, 1'b1, 1'b0, 4, 3'b000, 1, 1});
      vecs.push_back('{7'b0010011, 3'b000, 1'b1, 1'b0, 4, 3'b000, 1, 1});
      vecs.push_back('{7'b1100011, 3'b000, 1'b0, 1'b1, 3, 3'b001, 2, 0});
      vecs.push_back('{7'b1100011, 3'b000, 1'b0, 1'b0, 3, 3'b001, 1, 0});
      vecs.push_back('{7'b1101111, 3'b000, 1'b0, 1'b0, 4, 3'b000, 2, 1});
      vecs.push_back('{7'b1111111, 3'b000, 1'b0, 1'b0, 2, 3'b000, 1, 0});

      rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
`ifdef MEM_WAIT_EN
      mem_ready = 1'b1;
`endif
      #2;
      chk("reset_outputs", a_ctl, mk(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // Randomized instruction stream against the trace model
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 6) == 6) begin
            ok = 0;
            o = 7'd0;
            for (int t = 0; t < 20 && !ok; t++) begin
               o = 7'($urandom);
               ok = !is_legal(o);
            end
            if (!ok) o = 7'b1111111;
         end else begin
            o = legal_ops[$urandom_range(0, 5)];
         end
         op = o; funct3 = 3'($urandom); funct7b5 = 1'($urandom); zero = 1'($urandom);
         build(op, funct3, funct7b5, zero);
         run_model($sformatf("rand%0d_op%b", k, op));
      end

      // Reset in the middle of a load aborts it
      op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
      repeat (3) step();
      chk_int("pre_reset_memread", int'(a_st), 3);
      rst_n = 1'b0;
      #1;
      chk("reset_mid_memread", a_ctl, mk(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0));
      step();
      rst_n = 1'b1;
      #1;
      chk("release_fetch", a_ctl, mk(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0));
      build(op, funct3, funct7b5, zero);
      run_model("lw_after_reset");

`ifdef MEM_WAIT_EN
      op = 7'b0110011; funct3 = 3'b000;
      mem_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk_int($sformatf("wait%0d_state", c), int'(a_st), 0);
         chk_int($sformatf("wait%0d_irw", c), int'(a_irw), 0);
         chk_int($sformatf("wait%0d_pcw", c), int'(a_pcw), 0);
         step();
      end
      mem_ready = 1'b1;
      @(negedge clk);
      chk_int("ready_irw", int'(a_irw), 1);
      chk_int("ready_pcw", int'(a_pcw), 1);
      step();
      chk_int("ready_decode", int'(a_st), 1);
      for (int c = 0; c < 8 && a_st != 4'd0; c++) step();
      chk_int("wait_done_fetch", int'(a_st), 0);
`endif

      // Illegal opcode: one variant refetches, the other halts until reset
      op = 7'b1111111; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
      chk_int("halt_pre_b_state", int'(b_st), 0);
      @(negedge clk);
      chk("illegal_fetch", a_ctl, mk(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0));
      step();
      @(negedge clk);
      chk("illegal_decode_a", a_ctl, mk(4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 1));
      chk("illegal_decode_b", b_ctl, mk(4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 1));
      step();
      chk_int("illegal_refetch_a", int'(a_st), 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("halt_hold%0d", c), b_ctl, mk(4'd11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
